// File: rtl/pipe_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctl_if
// Brief    : Handshake bundle between the EX/ID/MA result producers and the
//            pipeline sequencer (branch/halt/hazard in, flush/stall/PC out).
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctl_if #(
    parameter int FE_DEPTH = 4
);
    logic                iw_branch_taken;
    logic [47:0]         iw_branch_pc;
    logic                iw_halt;
    logic                iw_resume;
    logic                iw_hzd_stall;
    logic                iw_mem_busy;
    logic                ow_pc_redirect;
    logic [47:0]         ow_redirect_pc;
    logic [FE_DEPTH-1:0] ow_flush_fe;
    logic                ow_flush_ex;
    logic [FE_DEPTH-1:0] ow_stall_fe;
    logic                ow_stall_ex;
    logic                ow_halted;
    logic [31:0]         ow_perf_redir;
    logic [31:0]         ow_perf_stall;

    // Producer side: stage results and hazard flags, observes control.
    modport master (
        output iw_branch_taken, iw_branch_pc, iw_halt, iw_resume,
               iw_hzd_stall, iw_mem_busy,
        input  ow_pc_redirect, ow_redirect_pc, ow_flush_fe, ow_flush_ex,
               ow_stall_fe, ow_stall_ex, ow_halted, ow_perf_redir, ow_perf_stall
    );

    // Sequencer side.
    modport slave (
        input  iw_branch_taken, iw_branch_pc, iw_halt, iw_resume,
               iw_hzd_stall, iw_mem_busy,
        output ow_pc_redirect, ow_redirect_pc, ow_flush_fe, ow_flush_ex,
               ow_stall_fe, ow_stall_ex, ow_halted, ow_perf_redir, ow_perf_stall
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctl
// Brief    : Pipeline sequencer for the amber core. Turns EX branch/halt
//            results and ID/MA hazard flags into registered PC redirect,
//            per-stage flush/stall and the halt/resume sequence.
//            Optional macro PIPECTL_PERF_EN builds saturating redirect and
//            stall-cycle counters; otherwise the perf outputs read 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctl #(
    parameter int          FE_DEPTH   = 4,
    parameter logic [47:0] RESUME_INC = 48'd1
) (
    input wire logic iw_clk,
    input wire logic iw_rst,
    pipe_ctl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REDIR  = 2'd1,
        ST_HALT   = 2'd2,
        ST_RESUME = 2'd3
    } state_t;

    localparam logic [FE_DEPTH-1:0] c_FE_ALL = '1;
    // Hazard freezes IA, IF and ID only; XT drains into the EX bubble.
    localparam logic [FE_DEPTH-1:0] c_FE_HZD = FE_DEPTH'(3'b111);

    state_t              r_state, w_state_nxt;
    logic                r_pend, w_pend_nxt;
    logic                r_pend_halt, w_pend_halt_nxt;
    logic [47:0]         r_pend_pc, w_pend_pc_nxt;
    logic [47:0]         r_save_pc, w_save_pc_nxt;
    logic                r_redirect, w_redirect_nxt;
    logic [47:0]         r_redirect_pc, w_redirect_pc_nxt;
    logic [FE_DEPTH-1:0] r_flush_fe, w_flush_fe_nxt;
    logic                r_flush_ex, w_flush_ex_nxt;
    logic [FE_DEPTH-1:0] r_stall_fe, w_stall_fe_nxt;
    logic                r_stall_ex, w_stall_ex_nxt;
    logic                r_halted, w_halted_nxt;

    // A branch parked during a memory wait is older than anything live, so it wins.
    logic        w_br;
    logic        w_br_halt;
    logic [47:0] w_br_pc;
    assign w_br      = r_pend | bus.iw_branch_taken;
    assign w_br_halt = r_pend ? r_pend_halt : bus.iw_halt;
    assign w_br_pc   = r_pend ? r_pend_pc   : bus.iw_branch_pc;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt       = r_state;
        w_pend_nxt        = r_pend;
        w_pend_halt_nxt   = r_pend_halt;
        w_pend_pc_nxt     = r_pend_pc;
        w_save_pc_nxt     = r_save_pc;
        w_redirect_nxt    = 1'b0;
        w_redirect_pc_nxt = r_redirect_pc;
        w_flush_fe_nxt    = '0;
        w_flush_ex_nxt    = 1'b0;
        w_stall_fe_nxt    = '0;
        w_stall_ex_nxt    = 1'b0;
        w_halted_nxt      = 1'b0;
        if (bus.iw_mem_busy) begin
            // Freeze everything; halted keeps its current meaning.
            w_stall_fe_nxt = c_FE_ALL;
            w_stall_ex_nxt = 1'b1;
            w_halted_nxt   = r_halted;
            if (r_state == ST_RUN && bus.iw_branch_taken && !r_pend) begin
                w_pend_nxt      = 1'b1;
                w_pend_halt_nxt = bus.iw_halt;
                w_pend_pc_nxt   = bus.iw_branch_pc;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_pend_nxt = 1'b0;
                    if (w_br) begin
                        w_flush_fe_nxt = c_FE_ALL;
                        w_flush_ex_nxt = 1'b1;
                        if (w_br_halt) begin
                            w_save_pc_nxt = w_br_pc;
                            w_halted_nxt  = 1'b1;
                            w_state_nxt   = ST_HALT;
                        end else begin
                            w_redirect_nxt    = 1'b1;
                            w_redirect_pc_nxt = w_br_pc;
                            w_state_nxt       = ST_REDIR;
                        end
                    end else if (bus.iw_hzd_stall) begin
                        w_stall_fe_nxt = c_FE_HZD;
                        w_flush_ex_nxt = 1'b1;
                    end
                end
                ST_REDIR: begin
                    // Wrong-path shadow: whatever EX reports now is discarded.
                    w_state_nxt = ST_RUN;
                end
                ST_HALT: begin
                    w_stall_fe_nxt = c_FE_ALL;
                    w_flush_ex_nxt = 1'b1;
                    w_halted_nxt   = 1'b1;
                    if (bus.iw_resume) w_state_nxt = ST_RESUME;
                end
                ST_RESUME: begin
                    w_redirect_nxt    = 1'b1;
                    w_redirect_pc_nxt = r_save_pc + RESUME_INC;
                    w_flush_fe_nxt    = c_FE_ALL;
                    w_state_nxt       = ST_REDIR;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // State, pending branch, saved halt PC and registered outputs.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state       <= ST_RUN;
            r_pend        <= 1'b0;
            r_pend_halt   <= 1'b0;
            r_pend_pc     <= '0;
            r_save_pc     <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush_fe    <= '0;
            r_flush_ex    <= 1'b0;
            r_stall_fe    <= '0;
            r_stall_ex    <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend        <= w_pend_nxt;
            r_pend_halt   <= w_pend_halt_nxt;
            r_pend_pc     <= w_pend_pc_nxt;
            r_save_pc     <= w_save_pc_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_flush_fe    <= w_flush_fe_nxt;
            r_flush_ex    <= w_flush_ex_nxt;
            r_stall_fe    <= w_stall_fe_nxt;
            r_stall_ex    <= w_stall_ex_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    assign bus.ow_pc_redirect = r_redirect;
    assign bus.ow_redirect_pc = r_redirect_pc;
    assign bus.ow_flush_fe    = r_flush_fe;
    assign bus.ow_flush_ex    = r_flush_ex;
    assign bus.ow_stall_fe    = r_stall_fe;
    assign bus.ow_stall_ex    = r_stall_ex;
    assign bus.ow_halted      = r_halted;

`ifdef PIPECTL_PERF_EN
    logic [31:0] r_perf_redir;
    logic [31:0] r_perf_stall;

    // Saturating event counters, tracking the registered outputs they describe.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_perf_redir <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_redirect_nxt && r_perf_redir != 32'hFFFF_FFFF)
                r_perf_redir <= r_perf_redir + 32'd1;
            if (((|w_stall_fe_nxt) || w_stall_ex_nxt) && r_perf_stall != 32'hFFFF_FFFF)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign bus.ow_perf_redir = r_perf_redir;
    assign bus.ow_perf_stall = r_perf_stall;
`else
    assign bus.ow_perf_redir = 32'd0;
    assign bus.ow_perf_stall = 32'd0;
`endif

endmodule
`default_nettype wire
